sonic_echo_ranger: RTL and testbench

//  Downstream of the ultrasonic trigger generator. Consumes its registered trigger pulses (trig1/trig2,

---
 rtl/sonic_pkg.sv | 26 ++
 rtl/sonic_echo_sync.sv | 49 ++++
 rtl/sonic_echo_ranger.sv | 233 +++++++++++++++++++++++
 tb/tb_sonic_echo_ranger.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// -----------------------------------------------------------------------------
// sonic_pkg
// Shared definitions for the ultrasonic ranging blocks (trigger generator and
// echo ranger).
//   DEF_TICKS_PER_CM : CLOCK_50 cycles per cm of range (58 us/cm at 50 MHz)
//   DEF_MAX_CM       : saturation / out-of-range distance in cm
//   DEF_DIST_W       : width of distance values (must hold DEF_MAX_CM)
//   DEF_ARM_TIMEOUT  : cycles allowed from trigger fall to echo rise (2 ms)
//   sonic_state_e    : echo ranger FSM state encoding
// -----------------------------------------------------------------------------
package sonic_pkg;

    localparam int DEF_TICKS_PER_CM = 2900;
    localparam int DEF_MAX_CM       = 400;
    localparam int DEF_DIST_W       = 9;
    localparam int DEF_ARM_TIMEOUT  = 100000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_WAIT_LOW  = 3'd4
    } sonic_state_e;

endpackage

// File: rtl/sonic_echo_sync.sv
// -----------------------------------------------------------------------------
// sonic_echo_sync
// Brings one asynchronous echo pin into the CLOCK_50 domain through a 2-FF
// synchronizer, plus a delay FF used for edge detection.
//   clk        in  : system clock
//   rst        in  : asynchronous active-high reset
//   echo_async in  : raw echo pin
//   echo_lvl   out : synchronized echo level
//   echo_rise  out : one-cycle pulse, synchronized echo went 0->1
//   echo_fall  out : one-cycle pulse, synchronized echo went 1->0
// -----------------------------------------------------------------------------
module sonic_echo_sync
    import sonic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic echo_async,
    output logic echo_lvl,
    output logic echo_rise,
    output logic echo_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;

    always_comb begin
        sync1_d = echo_async;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign echo_lvl  = sync2_q;
    assign echo_rise = sync2_q & ~dly_q;
    assign echo_fall = ~sync2_q & dly_q;

endmodule

// File: rtl/sonic_echo_ranger.sv
// -----------------------------------------------------------------------------
// sonic_echo_ranger
// Consumes trigger pulses for two alternating ultrasonic sensors, measures the
// selected sensor's echo pulse width and reports it in truncated centimetres.
// One result is reported per accepted trigger; a missing echo or an echo that
// reaches MAX_CM is reported as a timeout with distance MAX_CM.
//   CLOCK_50     in  : 50 MHz system clock
//   reset        in  : asynchronous active-high reset
//   trig1/trig2  in  : sensor trigger pulses (synchronous, trig1 has priority)
//   echo1/echo2  in  : asynchronous echo pins
//   dist_cm      out : last measured distance
//   dist_sensor  out : 0 = sensor 1, 1 = sensor 2
//   dist_timeout out : result was a timeout / out of range
//   dist_valid   out : one-cycle strobe, result outputs updated this cycle
//   dist1_cm     out : last sensor-1 distance
//   dist2_cm     out : last sensor-2 distance
// TICKS_PER_CM must be at least 2.
// -----------------------------------------------------------------------------
module sonic_echo_ranger #(
    parameter int TICKS_PER_CM = sonic_pkg::DEF_TICKS_PER_CM,
    parameter int MAX_CM       = sonic_pkg::DEF_MAX_CM,
    parameter int DIST_W       = sonic_pkg::DEF_DIST_W,
    parameter int ARM_TIMEOUT  = sonic_pkg::DEF_ARM_TIMEOUT
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              trig1,
    input  logic              trig2,
    input  logic              echo1,
    input  logic              echo2,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_sensor,
    output logic              dist_timeout,
    output logic              dist_valid,
    output logic [DIST_W-1:0] dist1_cm,
    output logic [DIST_W-1:0] dist2_cm
);

    import sonic_pkg::*;

    localparam int ARM_W  = $clog2(ARM_TIMEOUT + 1);
    localparam int TICK_W = $clog2(TICKS_PER_CM + 1);

    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_LAST   = DIST_W'(MAX_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

    // Echo synchronizers
    logic e1_lvl, e1_rise, e1_fall;
    logic e2_lvl, e2_rise, e2_fall;

    sonic_echo_sync u_sync1 (
        .clk        (CLOCK_50),
        .rst        (reset),
        .echo_async (echo1),
        .echo_lvl   (e1_lvl),
        .echo_rise  (e1_rise),
        .echo_fall  (e1_fall)
    );

    sonic_echo_sync u_sync2 (
        .clk        (CLOCK_50),
        .rst        (reset),
        .echo_async (echo2),
        .echo_lvl   (e2_lvl),
        .echo_rise  (e2_rise),
        .echo_fall  (e2_fall)
    );

    // State and counters
    sonic_state_e      state_q, state_d;
    logic              sel_q, sel_d;
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DIST_W-1:0] cm_q, cm_d;

    // Registered outputs
    logic [DIST_W-1:0] out_cm_q, out_cm_d;
    logic              out_sensor_q, out_sensor_d;
    logic              out_timeout_q, out_timeout_d;
    logic              out_valid_q, out_valid_d;
    logic [DIST_W-1:0] hold1_q, hold1_d;
    logic [DIST_W-1:0] hold2_q, hold2_d;

    // Selected-sensor views
    logic trig_sel, echo_lvl_sel, echo_rise_sel, echo_fall_sel;

    // Result emission request from the FSM
    logic              emit_en;
    logic              emit_timeout;
    logic [DIST_W-1:0] emit_cm;

    always_comb begin
        trig_sel      = sel_q ? trig2   : trig1;
        echo_lvl_sel  = sel_q ? e2_lvl  : e1_lvl;
        echo_rise_sel = sel_q ? e2_rise : e1_rise;
        echo_fall_sel = sel_q ? e2_fall : e1_fall;
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        arm_d         = arm_q;
        tick_d        = tick_q;
        cm_d          = cm_q;
        emit_en       = 1'b0;
        emit_timeout  = 1'b0;
        emit_cm       = '0;

        case (state_q)
            ST_IDLE: begin
                if (trig1) begin
                    state_d = ST_ARM;
                    sel_d   = 1'b0;
                end else if (trig2) begin
                    state_d = ST_ARM;
                    sel_d   = 1'b1;
                end
            end

            ST_ARM: begin
                if (!trig_sel) begin
                    state_d = ST_WAIT_RISE;
                    arm_d   = '0;
                end
            end

            ST_WAIT_RISE: begin
                if (echo_rise_sel) begin
                    // The cycle that shows the rising edge already has the
                    // echo high, so it is the first counted tick.
                    state_d = ST_MEASURE;
                    tick_d  = TICK_W'(1);
                    cm_d    = '0;
                end else if (arm_q == ARM_LAST) begin
                    state_d      = ST_IDLE;
                    emit_en      = 1'b1;
                    emit_timeout = 1'b1;
                    emit_cm      = CM_MAX;
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end

            ST_MEASURE: begin
                if (echo_fall_sel) begin
                    state_d = ST_IDLE;
                    emit_en = 1'b1;
                    emit_cm = cm_q;
                end else if (echo_lvl_sel) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        cm_d   = cm_q + DIST_W'(1);
                        if (cm_q == CM_LAST) begin
                            // Out of range: report now, then let the echo
                            // finish before accepting another trigger.
                            state_d      = ST_WAIT_LOW;
                            emit_en      = 1'b1;
                            emit_timeout = 1'b1;
                            emit_cm      = CM_MAX;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_WAIT_LOW: begin
                if (!echo_lvl_sel) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_cm_d      = out_cm_q;
        out_sensor_d  = out_sensor_q;
        out_timeout_d = out_timeout_q;
        out_valid_d   = 1'b0;
        hold1_d       = hold1_q;
        hold2_d       = hold2_q;
        if (emit_en) begin
            out_cm_d      = emit_cm;
            out_sensor_d  = sel_q;
            out_timeout_d = emit_timeout;
            out_valid_d   = 1'b1;
            if (sel_q) hold2_d = emit_cm;
            else       hold1_d = emit_cm;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            arm_q         <= '0;
            tick_q        <= '0;
            cm_q          <= '0;
            out_cm_q      <= '0;
            out_sensor_q  <= 1'b0;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b0;
            hold1_q       <= '0;
            hold2_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            arm_q         <= arm_d;
            tick_q        <= tick_d;
            cm_q          <= cm_d;
            out_cm_q      <= out_cm_d;
            out_sensor_q  <= out_sensor_d;
            out_timeout_q <= out_timeout_d;
            out_valid_q   <= out_valid_d;
            hold1_q       <= hold1_d;
            hold2_q       <= hold2_d;
        end
    end

    assign dist_cm      = out_cm_q;
    assign dist_sensor  = out_sensor_q;
    assign dist_timeout = out_timeout_q;
    assign dist_valid   = out_valid_q;
    assign dist1_cm     = hold1_q;
    assign dist2_cm     = hold2_q;

endmodule

// File: tb/tb_sonic_echo_ranger.sv
// -----------------------------------------------------------------------------
// tb_sonic_echo_ranger
// Drives trigger/echo transactions (directed boundary cases plus random ones)
// and compares every result strobe against a reference model that derives the
// expected distance from the echo width with plain arithmetic.
// Parameters are scaled down so saturation and arm timeout are reachable.
// -----------------------------------------------------------------------------
module tb_sonic_echo_ranger;

  localparam int TPC    = 10;
  localparam int MAXCM  = 12;
  localparam int DW     = 9;
  localparam int ARM_TO = 60;
  localparam int EW     = 3 * DW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic trig1 = 1'b0, trig2 = 1'b0, echo1 = 1'b0, echo2 = 1'b0;
  logic [DW-1:0] dist_cm, dist1_cm, dist2_cm;
  logic dist_sensor, dist_timeout, dist_valid;

  sonic_echo_ranger #(
    .TICKS_PER_CM (TPC),
    .MAX_CM       (MAXCM),
    .DIST_W       (DW),
    .ARM_TIMEOUT  (ARM_TO)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .trig1        (trig1),
    .trig2        (trig2),
    .echo1        (echo1),
    .echo2        (echo2),
    .dist_cm      (dist_cm),
    .dist_sensor  (dist_sensor),
    .dist_timeout (dist_timeout),
    .dist_valid   (dist_valid),
    .dist1_cm     (dist1_cm),
    .dist2_cm     (dist2_cm)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_strobe = 0;
  int h1 = 0;
  int h2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // result monitor: every strobe must match the oldest expected result
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && dist_valid) begin
      n_strobe++;
      check("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dist_cm",      dist_cm,      32'(e[DW-1:0]));
        check("dist_sensor",  dist_sensor,  32'(e[DW]));
        check("dist_timeout", dist_timeout, 32'(e[DW+1]));
        check("dist1_cm",     dist1_cm,     32'(e[2*DW+1:DW+2]));
        check("dist2_cm",     dist2_cm,     32'(e[3*DW+1:2*DW+2]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = trig1, 1 = trig2, 2 = both; width 0 = no echo at all
  task automatic run_meas(input int mode, input int dly, input int width,
                          input bit noise, input bit retrig);
    int sel, exp_cm, cnt, pw;
    bit exp_to;
    sel = (mode == 1) ? 1 : 0;
    if (width == 0 || width >= MAXCM * TPC) begin
      exp_to = 1'b1;
      exp_cm = MAXCM;
    end else begin
      exp_to = 1'b0;
      exp_cm = width / TPC;
    end
    if (sel == 1) h2 = exp_cm;
    else          h1 = exp_cm;
    exp_q.push_back({DW'(h2), DW'(h1), exp_to, 1'(sel), DW'(exp_cm)});
    n_push++;

    step();
    trig1 = (mode != 1);
    trig2 = (mode != 0);
    pw = $urandom_range(1, 3);
    repeat (pw) step();
    trig1 = 1'b0;
    trig2 = 1'b0;

    if (width == 0) begin
      // the next edge is the one that samples the trigger low
      @(posedge clk);
      cnt = 0;
      while (cnt < ARM_TO + 20) begin
        @(posedge clk);
        #1;
        cnt++;
        if (dist_valid) break;
      end
      check("arm_timeout_latency", cnt, ARM_TO);
    end else begin
      repeat (dly) step();
      if (sel == 1) echo2 = 1'b1;
      else          echo1 = 1'b1;
      for (int i = 1; i <= width; i++) begin
        step();
        if (noise) begin
          if (sel == 1) begin
            echo1 = 1'($urandom_range(0, 1));
            trig1 = (i < width) && ($urandom_range(0, 7) == 0);
          end else begin
            echo2 = 1'($urandom_range(0, 1));
            trig2 = (i < width) && ($urandom_range(0, 7) == 0);
          end
        end
        if (retrig) trig1 = (i >= MAXCM * TPC + 10) && (i < MAXCM * TPC + 13);
      end
      echo1 = 1'b0;
      echo2 = 1'b0;
      trig1 = 1'b0;
      trig2 = 1'b0;
      if (!exp_to) begin
        // first edge here is the one where sync FF1 samples echo low
        cnt = 0;
        while (cnt < 10) begin
          @(posedge clk);
          #1;
          cnt++;
          if (dist_valid) break;
        end
        check("echo_fall_latency", cnt, 3);
      end
    end

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      step();
      cnt++;
    end
    if (exp_q.size() != 0) begin
      check("strobe_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dist_cm"},      dist_cm,      0);
    check({tag, "_dist_sensor"},  dist_sensor,  0);
    check({tag, "_dist_timeout"}, dist_timeout, 0);
    check({tag, "_dist_valid"},   dist_valid,   0);
    check({tag, "_dist1_cm"},     dist1_cm,     0);
    check({tag, "_dist2_cm"},     dist2_cm,     0);
  endtask

  task automatic reset_mid_measure();
    step();
    trig1 = 1'b1;
    repeat (2) step();
    trig1 = 1'b0;
    repeat (5) step();
    echo1 = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    echo1 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    h1 = 0;
    h2 = 0;
    repeat (5) step();
    check("post_reset_no_strobe", n_strobe, n_push);
  endtask

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    int mode, kind, width, dly;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) step();

    run_meas(0, 20, 10 * TPC, 1'b0, 1'b0);           // 10 cm on sensor 1
    run_meas(1, 5, TPC - 1, 1'b0, 1'b0);             // just under 1 cm
    run_meas(1, 5, TPC, 1'b0, 1'b0);                 // exactly 1 cm
    run_meas(0, 0, 0, 1'b0, 1'b0);                   // no echo
    run_meas(0, 3, MAXCM * TPC - 1, 1'b0, 1'b0);     // one tick below range
    run_meas(0, 3, MAXCM * TPC, 1'b0, 1'b0);         // reaches range limit
    run_meas(0, 3, MAXCM * TPC + 40, 1'b0, 1'b1);    // retrigger while echo high
    run_meas(2, 4, 57, 1'b1, 1'b0);                  // both triggers, echo2 noise
    run_meas(1, 4, 35, 1'b1, 1'b0);                  // leaves nonzero outputs
    reset_mid_measure();
    run_meas(1, 2, 42, 1'b0, 1'b0);                  // FSM usable after reset

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      dly  = $urandom_range(0, ARM_TO - 10);
      if (kind == 0)      width = 0;
      else if (kind <= 2) width = MAXCM * TPC + $urandom_range(0, 30);
      else                width = $urandom_range(2, MAXCM * TPC - 1);
      run_meas(mode, dly, width, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (10) step();
    check("strobe_count", n_strobe, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
